// File: rtl/pid_scheduler.sv
// pid_scheduler
// Time-multiplexed PID engine. A free-running divider produces one control
// tick every TICK_DIV clocks; each tick walks channels 0..NUM_CH-1 through a
// fixed five-state pipeline (LOAD, ERR, MUL_P, MUL_I, OUT) that shares one
// signed 24x24 multiplier. Per-channel integrals and duty words live here.
//
// Ports:
//   CLK, reset_n        clock, asynchronous active-low reset
//   setpoint_flat       signed 24-bit setpoint per channel (channel k at [24k+23:24k])
//   state_flat          signed 24-bit measurement per channel, same packing
//   mode_flat           8-bit mode per channel; 3 = direct PWM from setpoint
//   enable              per-channel enable; disabled channels output 0
//   integral_clr        per-channel level-sensitive integral clear
//   Kp, Ki              shared signed gains
//   PWMLimit, IntegralLimit, deadband   shared limits (negative values act as 0)
//   overrun_clr         clears the sticky overrun flag
//   duty_flat           registered signed duty per channel
//   duty_strobe         one-cycle pulse when a channel's duty is written
//   busy                high while a channel sequence is in progress
//   overrun             sticky: a tick arrived while busy and was dropped
module pid_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int CLOCK_FREQ   = 16_000_000,
    parameter int CONTROL_FREQ = 1000
) (
    input  logic                 CLK,
    input  logic                 reset_n,
    input  logic [24*NUM_CH-1:0] setpoint_flat,
    input  logic [24*NUM_CH-1:0] state_flat,
    input  logic [8*NUM_CH-1:0]  mode_flat,
    input  logic [NUM_CH-1:0]    enable,
    input  logic [NUM_CH-1:0]    integral_clr,
    input  logic [23:0]          Kp,
    input  logic [23:0]          Ki,
    input  logic [23:0]          PWMLimit,
    input  logic [23:0]          IntegralLimit,
    input  logic [23:0]          deadband,
    input  logic                 overrun_clr,
    output logic [24*NUM_CH-1:0] duty_flat,
    output logic [NUM_CH-1:0]    duty_strobe,
    output logic                 busy,
    output logic                 overrun
);

    localparam int TICK_DIV = CLOCK_FREQ / CONTROL_FREQ;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ERR   = 3'd2,
        S_MUL_P = 3'd3,
        S_MUL_I = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    // Limits are interpreted as magnitudes; a negative limit collapses to 0.
    function automatic logic signed [24:0] nonneg_lim(input logic [23:0] lim);
        return lim[23] ? 25'sd0 : $signed({1'b0, lim});
    endfunction

    // Symmetric clamp of a 25-bit value into [-lim, +lim], returned as 24 bits.
    function automatic logic signed [23:0] clamp_sym(input logic signed [24:0] v,
                                                     input logic [23:0] lim);
        logic signed [24:0] l;
        logic signed [24:0] r;
        l = nonneg_lim(lim);
        if (v > l) begin
            r = l;
        end else if (v < -l) begin
            r = -l;
        end else begin
            r = v;
        end
        return r[23:0];
    endfunction

    state_t                state_q, state_d;
    logic [TICK_W-1:0]     cnt_q, cnt_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic signed [23:0]    sp_q, sp_d, st_q, st_d;
    logic signed [23:0]    kp_q, kp_d, ki_q, ki_d;
    logic [23:0]           pl_q, pl_d, il_q, il_d, db_q, db_d;
    logic [7:0]            mode_q, mode_d;
    logic                  en_q, en_d;
    logic signed [23:0]    err_q, err_d;
    logic signed [47:0]    acc_q, acc_d;
    logic [24*NUM_CH-1:0]  integ_q, integ_d;
    logic [24*NUM_CH-1:0]  duty_q, duty_d;
    logic [NUM_CH-1:0]     strobe_q, strobe_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;

    logic                  tick_s;
    logic signed [23:0]    integ_cur_s;
    logic signed [23:0]    diff_s;
    logic signed [23:0]    err_s;
    logic signed [24:0]    integ_sum_s;
    logic signed [47:0]    mul_a_s, mul_b_s, prod_s;
    logic signed [24:0]    r_ext_s, db_lim_s;
    logic signed [23:0]    r_out_s;

    // Datapath: error, integral candidate, shared multiplier and output shaping.
    always_comb begin
        tick_s      = (cnt_q == TICK_LAST);
        integ_cur_s = integ_q[ch_q*32'd24 +: 24];
        // Subtraction wraps in 24 bits before the arithmetic shift.
        diff_s      = sp_q - st_q;
        err_s       = diff_s >>> 3'd4;
        integ_sum_s = {integ_cur_s[23], integ_cur_s} + {err_s[23], err_s};
        // One multiplier: P operands in MUL_P, I operands otherwise.
        if (state_q == S_MUL_P) begin
            mul_a_s = {{24{kp_q[23]}}, kp_q};
            mul_b_s = {{24{err_q[23]}}, err_q};
        end else begin
            mul_a_s = {{24{ki_q[23]}}, ki_q};
            mul_b_s = {{24{integ_cur_s[23]}}, integ_cur_s};
        end
        prod_s   = mul_a_s * mul_b_s;
        r_ext_s  = {acc_q[23], acc_q[23:0]};
        db_lim_s = nonneg_lim(db_q);
        if (!en_q) begin
            r_out_s = 24'sd0;
        end else if (mode_q == 8'd3) begin
            r_out_s = clamp_sym({sp_q[23], sp_q}, pl_q);
        end else if ((r_ext_s >= -db_lim_s) && (r_ext_s <= db_lim_s)) begin
            r_out_s = 24'sd0;
        end else begin
            r_out_s = clamp_sym(r_ext_s, pl_q);
        end
    end

    // Next-state logic: tick divider, channel sequencer, snapshots and outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = tick_s ? {TICK_W{1'b0}} : (cnt_q + TICK_W'(1'b1));
        ch_d     = ch_q;
        sp_d     = sp_q;
        st_d     = st_q;
        kp_d     = kp_q;
        ki_d     = ki_q;
        pl_d     = pl_q;
        il_d     = il_q;
        db_d     = db_q;
        mode_d   = mode_q;
        en_d     = en_q;
        err_d    = err_q;
        acc_d    = acc_q;
        integ_d  = integ_q;
        duty_d   = duty_q;
        strobe_d = {NUM_CH{1'b0}};
        case (state_q)
            S_IDLE: begin
                if (tick_s) begin
                    ch_d    = {CH_W{1'b0}};
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                sp_d    = setpoint_flat[ch_q*32'd24 +: 24];
                st_d    = state_flat[ch_q*32'd24 +: 24];
                mode_d  = mode_flat[ch_q*32'd8 +: 8];
                en_d    = enable[ch_q];
                kp_d    = Kp;
                ki_d    = Ki;
                pl_d    = PWMLimit;
                il_d    = IntegralLimit;
                db_d    = deadband;
                state_d = S_ERR;
            end
            S_ERR: begin
                err_d = err_s;
                // Direct-PWM mode leaves the integral untouched.
                if (mode_q != 8'd3) begin
                    integ_d[ch_q*32'd24 +: 24] = clamp_sym(integ_sum_s, il_q);
                end else begin
                    integ_d[ch_q*32'd24 +: 24] = integ_cur_s;
                end
                state_d = S_MUL_P;
            end
            S_MUL_P: begin
                acc_d   = prod_s;
                state_d = S_MUL_I;
            end
            S_MUL_I: begin
                acc_d   = acc_q + prod_s;
                state_d = S_OUT;
            end
            S_OUT: begin
                duty_d[ch_q*32'd24 +: 24] = r_out_s;
                strobe_d[ch_q]            = 1'b1;
                if (!en_q) begin
                    integ_d[ch_q*32'd24 +: 24] = 24'd0;
                end else begin
                    integ_d[ch_q*32'd24 +: 24] = integ_cur_s;
                end
                if (ch_q == CH_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    ch_d    = ch_q + CH_W'(1'b1);
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Integral clear is level-sensitive and overrides any update above.
        for (int k = 0; k < NUM_CH; k++) begin
            integ_d[k*24 +: 24] = integral_clr[k] ? 24'd0 : integ_d[k*24 +: 24];
        end
        busy_d    = (state_d != S_IDLE);
        // A dropped tick sets the flag even when a clear is requested that cycle.
        overrun_d = (tick_s && (state_q != S_IDLE)) | (overrun_q & ~overrun_clr);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= {TICK_W{1'b0}};
            ch_q      <= {CH_W{1'b0}};
            sp_q      <= 24'sd0;
            st_q      <= 24'sd0;
            kp_q      <= 24'sd0;
            ki_q      <= 24'sd0;
            pl_q      <= 24'd0;
            il_q      <= 24'd0;
            db_q      <= 24'd0;
            mode_q    <= 8'd0;
            en_q      <= 1'b0;
            err_q     <= 24'sd0;
            acc_q     <= 48'sd0;
            integ_q   <= {(24*NUM_CH){1'b0}};
            duty_q    <= {(24*NUM_CH){1'b0}};
            strobe_q  <= {NUM_CH{1'b0}};
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            sp_q      <= sp_d;
            st_q      <= st_d;
            kp_q      <= kp_d;
            ki_q      <= ki_d;
            pl_q      <= pl_d;
            il_q      <= il_d;
            db_q      <= db_d;
            mode_q    <= mode_d;
            en_q      <= en_d;
            err_q     <= err_d;
            acc_q     <= acc_d;
            integ_q   <= integ_d;
            duty_q    <= duty_d;
            strobe_q  <= strobe_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign duty_flat   = duty_q;
    assign duty_strobe = strobe_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_pid_scheduler.sv
// Testbench for pid_scheduler: tick timing at the default rate, a table of
// hand-derived vectors, randomized ticks against a behavioural model, the
// overrun flag and reset in the middle of a sequence.
module tb_pid_scheduler;

    localparam int NCH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic [24*NCH-1:0]    setpoint_flat, state_flat;
    logic [8*NCH-1:0]     mode_flat;
    logic [NCH-1:0]       enable, integral_clr;
    logic [23:0]          kp, ki, pwm_limit, integral_limit, deadband;
    logic                 overrun_clr;

    logic [24*NCH-1:0]    duty_b, duty_f, duty_o;
    logic [NCH-1:0]       strobe_b, strobe_f, strobe_o;
    logic                 busy_b, busy_f, busy_o;
    logic                 ovr_b, ovr_f, ovr_o;

    // Default rate (TICK_DIV = 16000) for tick timing.
    pid_scheduler #(.NUM_CH(NCH), .CLOCK_FREQ(16_000_000), .CONTROL_FREQ(1000)) u_big (
        .CLK(clk), .reset_n(reset_n), .setpoint_flat(setpoint_flat), .state_flat(state_flat),
        .mode_flat(mode_flat), .enable(enable), .integral_clr(integral_clr), .Kp(kp), .Ki(ki),
        .PWMLimit(pwm_limit), .IntegralLimit(integral_limit), .deadband(deadband),
        .overrun_clr(overrun_clr), .duty_flat(duty_b), .duty_strobe(strobe_b), .busy(busy_b),
        .overrun(ovr_b));

    // TICK_DIV = 32 for functional checks.
    pid_scheduler #(.NUM_CH(NCH), .CLOCK_FREQ(32), .CONTROL_FREQ(1)) u_fast (
        .CLK(clk), .reset_n(reset_n), .setpoint_flat(setpoint_flat), .state_flat(state_flat),
        .mode_flat(mode_flat), .enable(enable), .integral_clr(integral_clr), .Kp(kp), .Ki(ki),
        .PWMLimit(pwm_limit), .IntegralLimit(integral_limit), .deadband(deadband),
        .overrun_clr(overrun_clr), .duty_flat(duty_f), .duty_strobe(strobe_f), .busy(busy_f),
        .overrun(ovr_f));

    // TICK_DIV = 12, shorter than a sequence, so ticks land while busy.
    pid_scheduler #(.NUM_CH(NCH), .CLOCK_FREQ(12), .CONTROL_FREQ(1)) u_ovr (
        .CLK(clk), .reset_n(reset_n), .setpoint_flat(setpoint_flat), .state_flat(state_flat),
        .mode_flat(mode_flat), .enable(enable), .integral_clr(integral_clr), .Kp(kp), .Ki(ki),
        .PWMLimit(pwm_limit), .IntegralLimit(integral_limit), .deadband(deadband),
        .overrun_clr(overrun_clr), .duty_flat(duty_o), .duty_strobe(strobe_o), .busy(busy_o),
        .overrun(ovr_o));

    int checks = 0;
    int errors = 0;
    int strobe_cnt [NCH];
    int seq_len;
    longint integ_m [NCH];
    longint exp_m [NCH];

    typedef struct {
        int ch; int sp; int st; int mode; bit en; bit clr;
        int kpv; int kiv; int pl; int il; int db; int exp_duty;
    } vec_t;
    vec_t vecs [14];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    function automatic logic signed [63:0] dsel(input logic [24*NCH-1:0] f, input int k);
        logic signed [23:0] v;
        v = f[k*24 +: 24];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference ----------------
    function automatic longint wrap24(input longint v);
        longint m;
        m = v & 64'hFFFFFF;
        if (m >= 64'sd8388608) m = m - 64'sd16777216;
        return m;
    endfunction

    function automatic longint s24(input logic [23:0] x);
        logic signed [23:0] t;
        t = x;
        return longint'(t);
    endfunction

    function automatic longint floor16(input longint d);
        if (d >= 0) return d / 16;
        else return -((-d + 15) / 16);
    endfunction

    function automatic longint clampl(input longint v, input longint l);
        if (v > l) return l;
        if (v < -l) return -l;
        return v;
    endfunction

    task automatic model_tick();
        longint sp, st, err, integ, r, pl, il, db, kpv, kiv;
        int mode;
        pl  = s24(pwm_limit);      if (pl < 0) pl = 0;
        il  = s24(integral_limit); if (il < 0) il = 0;
        db  = s24(deadband);       if (db < 0) db = 0;
        kpv = s24(kp);
        kiv = s24(ki);
        for (int k = 0; k < NCH; k++) begin
            sp    = s24(setpoint_flat[k*24 +: 24]);
            st    = s24(state_flat[k*24 +: 24]);
            mode  = int'(mode_flat[k*8 +: 8]);
            err   = floor16(wrap24(sp - st));
            integ = integ_m[k];
            if (mode != 3) integ = clampl(integ + err, il);
            if (integral_clr[k]) integ = 0;
            r = wrap24(kpv * err + kiv * integ);
            if (mode == 3) r = clampl(sp, pl);
            else if (r >= -db && r <= db) r = 0;
            else r = clampl(r, pl);
            if (!enable[k]) begin
                r = 0;
                integ = 0;
            end
            exp_m[k]   = r;
            integ_m[k] = integ;
        end
    endtask

    // ---------------- sequencing helpers ----------------
    task automatic wait_fast(input logic lvl, input string tag);
        int g = 0;
        while (busy_f !== lvl && g < 200) begin step(); g++; end
        check(tag, busy_f, lvl);
    endtask

    task automatic wait_ovr(input logic lvl, input string tag);
        int g = 0;
        while (busy_o !== lvl && g < 200) begin step(); g++; end
        check(tag, busy_o, lvl);
    endtask

    // Measures one full sequence of the selected instance from busy rise.
    task automatic measure_seq(input bit use_ovr);
        seq_len = 0;
        for (int k = 0; k < NCH; k++) strobe_cnt[k] = 0;
        for (int i = 0; i < 100; i++) begin
            for (int k = 0; k < NCH; k++)
                if ((use_ovr ? strobe_o[k] : strobe_f[k]) === 1'b1) strobe_cnt[k]++;
            if ((use_ovr ? busy_o : busy_f) !== 1'b1) break;
            seq_len++;
            step();
        end
    endtask

    task automatic run_fast_seq(input string tag);
        wait_fast(1'b1, {tag, "_start"});
        measure_seq(1'b0);
        check({tag, "_len"}, seq_len, 20);
        for (int k = 0; k < NCH; k++)
            check($sformatf("%s_strobe%0d", tag, k), strobe_cnt[k], 1);
    endtask

    task automatic clear_inputs();
        setpoint_flat = '0; state_flat = '0; mode_flat = '0;
        enable = '0; integral_clr = '0;
        kp = 24'd0; ki = 24'd0; pwm_limit = 24'd0; integral_limit = 24'd0; deadband = 24'd0;
    endtask

    task automatic apply_vec(input vec_t v);
        clear_inputs();
        setpoint_flat[v.ch*24 +: 24] = 24'(v.sp);
        state_flat[v.ch*24 +: 24]    = 24'(v.st);
        mode_flat[v.ch*8 +: 8]       = 8'(v.mode);
        enable[v.ch]                 = v.en;
        integral_clr[v.ch]           = v.clr;
        kp = 24'(v.kpv); ki = 24'(v.kiv);
        pwm_limit = 24'(v.pl); integral_limit = 24'(v.il); deadband = 24'(v.db);
    endtask

    function automatic logic [23:0] rnd_val(input int big_odds, input int small_mag);
        int v;
        if ($urandom_range(0, big_odds) == 0) return 24'($urandom);
        v = int'($urandom_range(0, 2 * small_mag)) - small_mag;
        return 24'(v);
    endfunction

    initial begin
        int first [NCH];
        int busy_cnt, busy_first, cnt, seen;

        //             ch  sp       st     md en clr kp  ki pl       il    db exp
        vecs[0]  = '{0, 1600,    0,     0, 1, 0, 2,   1, 1000,    1000, 0,  300};
        vecs[1]  = '{0, 1600,    0,     0, 1, 0, 2,   1, 1000,    1000, 0,  400};
        vecs[2]  = '{1, -5000,   0,     3, 1, 0, 2,   1, 2000,    1000, 0,  -2000};
        vecs[3]  = '{1, 0,       0,     0, 1, 0, 0,   1, 1000,    1000, 0,  0};
        vecs[4]  = '{2, 48,      0,     0, 1, 0, 3,   0, 1000,    1000, 10, 0};
        vecs[5]  = '{2, 48,      0,     0, 1, 0, 3,   0, 1000,    1000, 8,  9};
        vecs[6]  = '{3, 1600,    0,     0, 1, 0, 2,   1, 1000,    50,   0,  250};
        vecs[7]  = '{3, 1600,    0,     0, 1, 0, 2,   1, 1000,    50,   0,  250};
        vecs[8]  = '{3, 1600,    0,     0, 1, 0, 2,   1, 1000,    50,   0,  250};
        vecs[9]  = '{3, 1600,    0,     0, 1, 1, 2,   1, 1000,    50,   0,  200};
        vecs[10] = '{0, 1600,    0,     0, 0, 0, 2,   1, 1000,    1000, 0,  0};
        vecs[11] = '{0, 1600,    0,     0, 1, 0, 2,   1, 1000,    1000, 0,  300};
        vecs[12] = '{2, 0,       16000, 0, 1, 0, 100, 0, 5000,    1000, 0,  -5000};
        vecs[13] = '{1, 8388607, -1,    0, 1, 0, 1,   0, 8388607, 1000, 0,  -524288};

        // ---------------- reset state and tick timing ----------------
        reset_n = 1'b0;
        overrun_clr = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NCH; k++) check($sformatf("rst_duty%0d", k), dsel(duty_b, k), 0);
        check("rst_strobe", strobe_b, 0);
        check("rst_busy", busy_b, 0);
        check("rst_overrun", ovr_b, 0);

        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < NCH; k++) first[k] = 0;
        busy_cnt = 0;
        busy_first = 0;
        for (int e = 1; e <= 16040; e++) begin
            step();
            for (int k = 0; k < NCH; k++)
                if (strobe_b[k] === 1'b1 && first[k] == 0) first[k] = e;
            if (busy_b === 1'b1) begin
                busy_cnt++;
                if (busy_first == 0) busy_first = e;
            end
        end
        for (int k = 0; k < NCH; k++)
            check($sformatf("first_strobe_ch%0d", k), first[k], 16000 + 5 * (k + 1));
        check("busy_first_edge", busy_first, 16000);
        check("busy_cycles", busy_cnt, 20);

        // ---------------- table-driven vectors ----------------
        foreach (vecs[i]) begin
            wait_fast(1'b0, $sformatf("vec%0d_idle", i));
            apply_vec(vecs[i]);
            run_fast_seq($sformatf("vec%0d", i));
            for (int k = 0; k < NCH; k++)
                check($sformatf("vec%0d_duty%0d", i, k), dsel(duty_f, k),
                      (k == vecs[i].ch) ? vecs[i].exp_duty : 0);
        end

        // ---------------- randomized against the model ----------------
        wait_fast(1'b0, "rnd_sync_idle");
        clear_inputs();
        run_fast_seq("rnd_sync");
        for (int k = 0; k < NCH; k++) integ_m[k] = 0;
        for (int it = 0; it < 30; it++) begin
            wait_fast(1'b0, $sformatf("rnd%0d_idle", it));
            for (int k = 0; k < NCH; k++) begin
                setpoint_flat[k*24 +: 24] = rnd_val(3, 40000);
                state_flat[k*24 +: 24]    = rnd_val(3, 40000);
                mode_flat[k*8 +: 8]       = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                                                        : 8'($urandom_range(0, 3));
                enable[k]                 = ($urandom_range(0, 4) != 0);
                integral_clr[k]           = ($urandom_range(0, 6) == 0);
            end
            kp = rnd_val(5, 300);
            ki = rnd_val(5, 300);
            pwm_limit      = 24'($urandom_range(0, 2000000));
            integral_limit = 24'($urandom_range(0, 20000));
            deadband       = 24'($urandom_range(0, 500));
            model_tick();
            run_fast_seq($sformatf("rnd%0d", it));
            for (int k = 0; k < NCH; k++)
                check($sformatf("rnd%0d_duty%0d", it, k), dsel(duty_f, k), exp_m[k]);
        end
        check("fast_no_overrun", ovr_f, 0);

        // ---------------- overrun behaviour ----------------
        wait_ovr(1'b1, "ovr_a_start");
        wait_ovr(1'b0, "ovr_a_end");
        check("ovr_set_before_clr", ovr_o, 1);
        overrun_clr = 1'b1;
        step();
        check("ovr_cleared", ovr_o, 0);
        overrun_clr = 1'b0;
        wait_ovr(1'b1, "ovr_b_start");
        measure_seq(1'b1);
        check("ovr_seq_len", seq_len, 20);
        for (int k = 0; k < NCH; k++) check($sformatf("ovr_strobe%0d", k), strobe_cnt[k], 1);
        check("ovr_set_by_drop", ovr_o, 1);
        overrun_clr = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (ovr_o === 1'b1) seen = 1;
        end
        check("ovr_set_wins", seen, 1);
        overrun_clr = 1'b0;

        // ---------------- reset in the middle of a sequence ----------------
        wait_ovr(1'b0, "mid_idle");
        clear_inputs();
        enable = '1;
        setpoint_flat[23:0] = 24'd1600;
        kp = 24'd2; pwm_limit = 24'd1000; integral_limit = 24'd1000;
        wait_ovr(1'b1, "mid_start");
        repeat (5) step();
        check("mid_duty0_before", dsel(duty_o, 0), 200);
        repeat (2) step();
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_strobe", strobe_o, 0);
        check("mid_rst_overrun", ovr_o, 0);
        for (int k = 0; k < NCH; k++) check($sformatf("mid_rst_duty%0d", k), dsel(duty_o, k), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (strobe_o !== '0 || busy_o !== 1'b0) cnt++;
        end
        check("post_rst_quiet", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pid_scheduler.md
Name: pid_scheduler

Overview:
- Time-multiplexed PID engine serving NUM_CH motor channels from one shared 24x24 multiplier.
- Generates the control tick, then sequences channels 0..NUM_CH-1 one at a time.
- Keeps per-channel integral state and drives one registered duty word per channel to the PWM generators.
- Replaces per-motor PID instances on the motor board to save multipliers.

Parameters:
- NUM_CH, 4, number of motor channels (1..8).
- CLOCK_FREQ, 16_000_000, system clock in Hz.
- CONTROL_FREQ, 1000, control loop rate in Hz. TICK_DIV = CLOCK_FREQ/CONTROL_FREQ.

Ports:
- CLK  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- setpoint_flat  in  24*NUM_CH  signed setpoint, channel k at bits [24k+23:24k].
- state_flat  in  24*NUM_CH  signed measured state, same packing.
- mode_flat  in  8*NUM_CH  control_mode per channel; value 3 selects direct PWM.
- enable  in  NUM_CH  per-channel enable.
- integral_clr  in  NUM_CH  per-channel integral clear, level-sensitive.
- Kp, Ki  in  24 each  signed gains, shared by all channels.
- PWMLimit, IntegralLimit, deadband  in  24 each  signed, treated as non-negative, shared.
- overrun_clr  in  1  clears the overrun flag.
- duty_flat  out  24*NUM_CH  signed duty per channel, registered.
- duty_strobe  out  NUM_CH  one-cycle pulse when channel k duty is written.
- busy  out  1  high whenever the FSM is not in IDLE.
- overrun  out  1  sticky; a tick arrived while busy.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All duty = 0, all integrals = 0, tick counter = 0.
  - FSM goes to IDLE; duty_strobe = 0, busy = 0, overrun = 0.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is an internal one-cycle pulse registered when the counter wraps to 0. Period is exactly TICK_DIV cycles.
- FSM states: IDLE, LOAD, ERR, MUL_P, MUL_I, OUT.
  - IDLE: on tick, set ch = 0 and go to LOAD.
  - LOAD: snapshot setpoint, state, mode and enable for channel ch, plus all shared inputs.
  - ERR: err = (sp - st) >>> 4. The subtraction wraps in 24 bits before the shift.
    - Integral: integ = integ + err (25-bit intermediate), then saturate to [-IntegralLimit, +IntegralLimit] and store.
  - MUL_P: acc = Kp*err, 48-bit.
  - MUL_I: acc = acc + Ki*integ, 48-bit. The multiplier is used exactly once per state.
  - OUT:
    - r = acc[23:0].
    - If mode == 3: r = sp clamped to ±PWMLimit; integral is untouched; the ERR/MUL states still occupy their slots.
    - Otherwise: if -deadband <= r <= deadband then r = 0, else r is clamped to ±PWMLimit.
    - If the channel is disabled, r = 0 and the integral is forced to 0.
    - Write duty[ch] = r and pulse duty_strobe[ch] for one cycle.
    - If ch == NUM_CH-1 go to IDLE, else ch+1 and go to LOAD.
- Timing:
  - Each channel takes exactly 5 cycles. Duty for channel k is written on the edge 5(k+1) cycles after the edge that registers tick.
  - busy stays high for 5*NUM_CH cycles.
  - Requires 5*NUM_CH < TICK_DIV.
- integral_clr[k]: while high, integral k is held at 0. This takes priority over the ERR-state update, and err still applies to the P term.
- Tick while busy:
  - The tick is dropped and overrun is set.
  - The sequence in progress completes unchanged; no restart.
- overrun_clr:
  - Clears overrun on the next edge.
  - If overrun_clr and a new overrun occur in the same cycle, set wins.
- Disabled channels keep their time slot, so timing is deterministic.
- Inputs may change at any time; only the LOAD snapshot is used.
- Reset mid-sequence: all state is cleared immediately and no strobe fires.

Test Plan:
- Reset release, TICK_DIV=16000, NUM_CH=4 -> first strobe on ch0 exactly 16000+5 edges after reset release; strobes on ch1..3 follow at +5, +10, +15 cycles; busy is high for 20 cycles.
- Ch0: sp=1600, st=0, Kp=2, Ki=1, limits 1000/1000, deadband 0, mode 0 -> tick1 duty=300; tick2 duty=400 (integral=200).
- Ch1: mode 3, sp=-5000, PWMLimit=2000 -> duty=-2000; integral 1 stays 0.
- Ch2: sp=48, st=0, Kp=3, Ki=0, deadband=10 -> err=3, r=9, duty=0. With deadband=8 -> duty=9.
- Saturation: Ki=1, IntegralLimit=50, err=100 for 3 ticks -> integral pinned at 50. Then integral_clr=1 -> next duty = Kp*err only.
- Force a tick during busy (test TICK_DIV small, e.g. 12 with NUM_CH=4) -> overrun=1, all 4 strobes still occur once; overrun_clr -> overrun=0 next cycle. Assert reset_n low mid-sequence -> all duty=0 immediately, busy=0.
